conv_pe_mac: RTL

Processing element at the PE end of the memory-controller/PE data interface. It consumes streamed ifmap/filter pairs plus an initial partial sum, and performs a multiply-accumulate over kernel_size beats. It returns the finished partial sum with a one-cycle valid pulse. Accepted ifmap/filter beats are forwarded, registered, to the neighbouring PE.

---
 rtl/conv_pe_mac_if.sv | 27 ++
 rtl/conv_pe_mac.sv | 96 +++++++++
 2 files changed

// File: rtl/conv_pe_mac_if.sv
// Data interface between the memory controller and a conv PE.
// The controller drives the beat inputs, and the PE returns the forwarded beat and the result.
interface conv_pe_mac_if #(
    parameter int DATA_WIDTH = 16,
    parameter int KS_WIDTH   = 8
);
    logic                    pe_en;
    logic [KS_WIDTH-1:0]     kernel_size;
    logic [DATA_WIDTH-1:0]   ifmap_data_in;
    logic [DATA_WIDTH-1:0]   fltr_data_in;
    logic [2*DATA_WIDTH-1:0] psum_data_in;
    logic [DATA_WIDTH-1:0]   ifmap_data_out;
    logic [DATA_WIDTH-1:0]   fltr_data_out;
    logic [2*DATA_WIDTH-1:0] psum_data_out;
    logic                    pe_ready;
    logic                    pe_valid;

    modport master (
        output pe_en, kernel_size, ifmap_data_in, fltr_data_in, psum_data_in,
        input  ifmap_data_out, fltr_data_out, psum_data_out, pe_ready, pe_valid
    );

    modport slave (
        input  pe_en, kernel_size, ifmap_data_in, fltr_data_in, psum_data_in,
        output ifmap_data_out, fltr_data_out, psum_data_out, pe_ready, pe_valid
    );
endinterface

// File: rtl/conv_pe_mac.sv
// Conv PE: accumulates kernel_size ifmap*filter products onto an initial psum.
// It forwards accepted operand beats to the neighbouring PE.
module conv_pe_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int KS_WIDTH   = 8
) (
    input  logic          clk,
    input  logic          rstn,
    conv_pe_mac_if.slave  bus
);
    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                state, state_next;
    logic                  ready_q;
    logic                  ready_c;
    logic                  valid_c;
    logic                  accept;
    logic [KS_WIDTH-1:0]   ks_q;
    logic [KS_WIDTH-1:0]   cnt_q;
    logic [KS_WIDTH-1:0]   ks_first;
    logic [PW-1:0]         acc_q;
    logic [PW-1:0]         psum_q;
    logic [PW-1:0]         prod;
    logic [PW-1:0]         acc_next;
    logic [DATA_WIDTH-1:0] ifmap_q;
    logic [DATA_WIDTH-1:0] fltr_q;

    assign accept   = bus.pe_en && ready_c;
    assign ks_first = (bus.kernel_size == '0) ? KS_WIDTH'(1) : bus.kernel_size;
    assign prod     = PW'(bus.ifmap_data_in) * PW'(bus.fltr_data_in);
    // The first beat of a window seeds from psum_data_in. Later beats build on the accumulator.
    assign acc_next = ((state == IDLE) ? bus.psum_data_in : acc_q) + prod;

    assign bus.pe_ready       = ready_c;
    assign bus.pe_valid       = valid_c;
    assign bus.psum_data_out  = psum_q;
    assign bus.ifmap_data_out = ifmap_q;
    assign bus.fltr_data_out  = fltr_q;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and handshake outputs.
    // ready_q keeps pe_ready low during reset and until the first clock edge after reset.
    always_comb begin
        state_next = state;
        ready_c    = ready_q;
        valid_c    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = (ks_first == KS_WIDTH'(1)) ? DONE : ACC;
            end
            ACC: begin
                if (accept && (cnt_q + KS_WIDTH'(1) == ks_q)) state_next = DONE;
            end
            DONE: begin
                ready_c    = 1'b0;
                valid_c    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: accumulator, beat counter, latched kernel size, result and forwarding registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_q <= 1'b0;
            ks_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            psum_q  <= '0;
            ifmap_q <= '0;
            fltr_q  <= '0;
        end else begin
            ready_q <= 1'b1;
            if (accept) begin
                ifmap_q <= bus.ifmap_data_in;
                fltr_q  <= bus.fltr_data_in;
                acc_q   <= acc_next;
                if (state == IDLE) begin
                    ks_q  <= ks_first;
                    cnt_q <= KS_WIDTH'(1);
                end else begin
                    cnt_q <= cnt_q + KS_WIDTH'(1);
                end
                if (state_next == DONE) psum_q <= acc_next;
            end
        end
    end
endmodule
